// File: rtl/button_debouncer_if.sv
// Button debouncer interface: bundles the tick enable, the raw button input
// and the four debounced outputs. The master side feeds tick/btn_in and
// observes the outputs; the slave side is the debouncer itself.
interface button_debouncer_if;
  logic tick;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output tick,
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  tick,
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer.
// Cleans up one raw mechanical push-button. The raw input is first brought
// into the clk domain through a two-flop synchronizer, then a four-state FSM
// requires the new level to hold for STABLE_TICKS consecutive ticks before it
// is accepted. While the press is held, a saturating tick counter fires a
// single long-press pulse after LONG_TICKS ticks. All timing is measured in
// ticks (a one-clk enable from an upstream clock divider); every output is
// a registered flop.
module button_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 100
) (
  input logic              clk,
  input logic              rst,
  button_debouncer_if.slave bus
);

  localparam int CNT_W  = $clog2(STABLE_TICKS) + 1;
  localparam int LCNT_W = $clog2(LONG_TICKS) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_TICKS - 1);

  // IDLE      : released and stable
  // ARMING    : raw level went high, waiting for it to stay high long enough
  // HELD      : press accepted, long-press timer running
  // DISARMING : raw level went low while held, waiting for it to stay low
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              long_done_q, long_done_d;
  logic              btn_level_q, btn_level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  logic btn_s;

  assign btn_s = sync2_q;

  // Two-flop synchronizer: the raw button is asynchronous to clk.
  always_comb begin
    sync1_d = bus.btn_in;
    sync2_d = sync1_q;
  end

  // Next-state and output logic. Pulses default low so each is one clk wide;
  // a level reversal is checked before the tick so it always wins a tie.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    btn_level_d = btn_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end

      ARMING: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d     = HELD;
            press_d     = 1'b1;
            btn_level_d = 1'b1;
            lcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_d = DISARMING;
          cnt_d   = '0;
        end else if (bus.tick && !long_done_q) begin
          // lcnt stops at its last value once the long pulse has fired,
          // so it saturates rather than wrapping.
          if (lcnt_q == LCNT_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end

      DISARMING: begin
        // A bounce back to high resumes HELD with the long-press progress
        // intact; lcnt is frozen while we wait here.
        if (btn_s) begin
          state_d = HELD;
        end else if (bus.tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d     = IDLE;
            release_d   = 1'b1;
            btn_level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset. Reset drops everything
  // to zero without emitting a release pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign bus.btn_level     = btn_level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer.
// Directed scenarios followed by a randomized run; every cycle the DUT outputs
// are compared with a behavioural model that tracks the accepted level and how
// many ticks a disagreeing raw level has persisted.
module tb_button_debouncer;

  localparam int STABLE = 4;
  localparam int LONG   = 10;

  logic clk;
  logic rst;

  button_debouncer_if bus ();

  button_debouncer #(
    .STABLE_TICKS (STABLE),
    .LONG_TICKS   (LONG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int long_cnt = 0;
  int phase = 0;
  string cur_tag = "init";

  // Reference model state
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_release = 1'b0;
  logic m_long = 1'b0;
  bit   m_pending = 1'b0;
  int   m_pend_ticks = 0;
  int   m_held_ticks = 0;
  bit   m_long_fired = 1'b0;

  // Behavioural model: the synchronized input is the raw input two edges
  // late. Whenever it disagrees with the accepted level, ticks are counted
  // (the edge that first sees the disagreement does not count); after STABLE
  // such ticks the level flips. Agreement before then cancels the attempt.
  // While pressed and not disagreeing, ticks accumulate toward one long pulse.
  always @(posedge clk) begin
    logic b;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0;
      m_press = 0; m_release = 0; m_long = 0;
      m_pending = 0; m_pend_ticks = 0; m_held_ticks = 0; m_long_fired = 0;
    end else begin
      b = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.btn_in;
      m_press = 0; m_release = 0; m_long = 0;
      if (!m_pending) begin
        if (b != m_level) begin
          m_pending = 1;
          m_pend_ticks = 0;
        end else if (m_level && bus.tick && !m_long_fired) begin
          m_held_ticks++;
          if (m_held_ticks == LONG) begin
            m_long = 1;
            m_long_fired = 1;
          end
        end
      end else begin
        if (b == m_level) begin
          m_pending = 0;
        end else if (bus.tick) begin
          m_pend_ticks++;
          if (m_pend_ticks == STABLE) begin
            m_pending = 0;
            m_level = ~m_level;
            if (m_level) begin
              m_press = 1;
              m_held_ticks = 0;
              m_long_fired = 0;
            end else begin
              m_release = 1;
            end
          end
        end
      end
    end
  end

  task automatic checkValue(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic checkOutput();
    checkValue({cur_tag, "_level"},   int'(bus.btn_level),     int'(m_level));
    checkValue({cur_tag, "_press"},   int'(bus.press_pulse),   int'(m_press));
    checkValue({cur_tag, "_release"}, int'(bus.release_pulse), int'(m_release));
    checkValue({cur_tag, "_long"},    int'(bus.long_pulse),    int'(m_long));
    checkValue({cur_tag, "_pr_overlap"},
               int'(bus.press_pulse & bus.release_pulse), 0);
    if (bus.press_pulse === 1'b1)   press_cnt++;
    if (bus.release_pulse === 1'b1) release_cnt++;
    if (bus.long_pulse === 1'b1)    long_cnt++;
  endtask

  task automatic applyStimulus(input logic b, input logic t, input logic r);
    bus.btn_in = b;
    bus.tick   = t;
    rst        = r;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runTicked(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(b, phase == 4, 1'b1);
      phase = (phase + 1) % 5;
    end
  endtask

  int p0, r0, l0;
  int hold;
  logic rb;

  initial begin
    bus.btn_in = 1'b0;
    bus.tick   = 1'b0;
    rst        = 1'b0;
    @(negedge clk);

    // Reset state
    cur_tag = "reset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("reset_level", int'(bus.btn_level), 0);

    // Clean press
    cur_tag = "s1";
    runTicked(1'b0, 10);
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    runTicked(1'b1, 30);
    checkValue("s1_press_count", press_cnt - p0, 1);
    checkValue("s1_level", int'(bus.btn_level), 1);
    checkValue("s1_no_early_long", long_cnt - l0, 0);

    // Long press then release
    cur_tag = "s3";
    runTicked(1'b1, 100);
    checkValue("s3_long_count", long_cnt - l0, 1);
    runTicked(1'b0, 40);
    checkValue("s3_release_count", release_cnt - r0, 1);
    checkValue("s3_level", int'(bus.btn_level), 0);
    checkValue("s3_long_once", long_cnt - l0, 1);

    // Bounce: toggle every 7 clk for 60 clk, then settle low
    cur_tag = "s2";
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    for (int i = 0; i < 60; i++) runTicked(((i / 7) % 2) == 0, 1);
    runTicked(1'b0, 40);
    checkValue("s2_press_count", press_cnt - p0, 0);
    checkValue("s2_release_count", release_cnt - r0, 0);
    checkValue("s2_long_count", long_cnt - l0, 0);
    checkValue("s2_level", int'(bus.btn_level), 0);

    // Release bounce while held: long still fires exactly once
    cur_tag = "s4";
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    runTicked(1'b1, 50);
    checkValue("s4_press_count", press_cnt - p0, 1);
    checkValue("s4_no_long_yet", long_cnt - l0, 0);
    runTicked(1'b0, 10);
    runTicked(1'b1, 70);
    checkValue("s4_no_release", release_cnt - r0, 0);
    checkValue("s4_long_count", long_cnt - l0, 1);
    runTicked(1'b0, 40);
    checkValue("s4_release_count", release_cnt - r0, 1);

    // Tick/edge collision: btn_s falls on the edge of the 4th ARMING tick
    cur_tag = "s5";
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    p0 = press_cnt;
    for (int i = 0; i < 15; i++) applyStimulus(i < 4, (i >= 3) && (i <= 6), 1'b1);
    checkValue("s5_collision_no_press", press_cnt - p0, 0);
    checkValue("s5_level", int'(bus.btn_level), 0);
    // Same timing but the level survives the 4th tick: press confirmed
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    p0 = press_cnt; r0 = release_cnt;
    for (int i = 0; i < 15; i++) applyStimulus(i < 5, (i >= 3) && (i <= 6), 1'b1);
    checkValue("s5_control_press", press_cnt - p0, 1);
    runTicked(1'b0, 40);
    checkValue("s5_control_release", release_cnt - r0, 1);

    // Reset mid-press with the button still held
    cur_tag = "s6";
    runTicked(1'b1, 30);
    checkValue("s6_level_before", int'(bus.btn_level), 1);
    p0 = press_cnt; r0 = release_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkValue("s6_level_after_reset", int'(bus.btn_level), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTicked(1'b1, 40);
    checkValue("s6_no_release", release_cnt - r0, 0);
    checkValue("s6_new_press", press_cnt - p0, 1);
    checkValue("s6_level_final", int'(bus.btn_level), 1);
    runTicked(1'b0, 40);

    // Randomized run against the model
    cur_tag = "rand";
    hold = 0;
    rb = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        rb = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 80);
      end
      hold--;
      applyStimulus(rb, $urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
